// File: rtl/dmem_responder_if.sv
// Load/store port between the core's MA stage and the data-memory responder,
// including the console TX stream and the halt/exit signalling back to the host.
interface dmem_responder_if;
    logic        wem;
    logic [2:0]  rwmm;
    logic [31:0] rwam;
    logic [31:0] wdm;
    logic [31:0] rdm;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halt;
    logic [31:0] exit_code;

    modport master (
        output wem, rwmm, rwam, wdm, tx_ready,
        input  rdm, tx_data, tx_valid, halt, exit_code
    );

    modport slave (
        input  wem, rwmm, rwam, wdm, tx_ready,
        output rdm, tx_data, tx_valid, halt, exit_code
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte-lane stores and extended loads,
// plus an MMIO window (cycle counter, tohost halt, console TX FIFO, status).
// Loads are combinational; stores and MMIO side effects commit on the clock
// edge that ends the MA cycle. There is no separate read strobe, so every
// cycle is treated as an access for alignment-fault tracking.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int FIFO_DEPTH  = 4
) (
    input logic              clk,
    input logic              reset,
    dmem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // Access decode
    logic          is_byte;
    logic          is_half;
    logic          is_word;
    logic          is_unsigned;
    logic          misaligned;
    logic          is_mmio;
    logic [1:0]    lane;
    logic [1:0]    reg_sel;
    logic [AW-1:0] word_idx;

    // Store lane placement
    logic [3:0]    byte_en;
    logic [31:0]   placed;
    logic [31:0]   tohost_data;
    logic          store_ok;
    logic          ram_we;
    logic          tohost_we;

    // Architectural state
    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   cycle_count;
    logic          halt_reg;
    logic [31:0]   exit_reg;
    logic          mis;
    logic [31:0]   mis_addr;
    logic          ovf;

    // Console FIFO
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          push_req;
    logic          push_ok;
    logic [7:0]    head;
    logic [3:0]    count_nib;

    // Load path
    logic [31:0]   status_word;
    logic [31:0]   mmio_word;
    logic [31:0]   ram_word;
    logic [31:0]   src_word;
    logic [7:0]    byte_pick;
    logic [15:0]   half_pick;
    logic [31:0]   load_data;

    logic          unused_addr_bits;

    assign is_mmio  = bus.rwam[31];
    assign lane     = bus.rwam[1:0];
    assign reg_sel  = bus.rwam[3:2];
    assign word_idx = bus.rwam[AW+1:2];
    assign unused_addr_bits = ^bus.rwam;

    // Decode the funct3 access mode; unlisted codes fall through to word.
    always_comb begin
        is_byte     = 1'b0;
        is_half     = 1'b0;
        is_unsigned = 1'b0;
        case (bus.rwmm)
            3'b000: is_byte = 1'b1;
            3'b001: is_half = 1'b1;
            3'b100: begin
                is_byte     = 1'b1;
                is_unsigned = 1'b1;
            end
            3'b101: begin
                is_half     = 1'b1;
                is_unsigned = 1'b1;
            end
            default: ;
        endcase
    end

    assign is_word    = ~is_byte & ~is_half;
    assign misaligned = (is_half & bus.rwam[0]) | (is_word & (lane != 2'b00));

    // Replicate store data across lanes and pick which lanes get written.
    always_comb begin
        byte_en = 4'b0000;
        placed  = 32'h0;
        if (is_byte) begin
            placed  = {4{bus.wdm[7:0]}};
            byte_en = 4'b0001 << lane;
        end else if (is_half) begin
            placed  = {2{bus.wdm[15:0]}};
            byte_en = bus.rwam[1] ? 4'b1100 : 4'b0011;
        end else begin
            placed  = bus.wdm;
            byte_en = 4'b1111;
        end
    end

    assign tohost_data = placed & {{8{byte_en[3]}}, {8{byte_en[2]}},
                                   {8{byte_en[1]}}, {8{byte_en[0]}}};

    assign store_ok  = bus.wem & ~misaligned;
    assign ram_we    = store_ok & ~is_mmio;
    assign tohost_we = store_ok & is_mmio & (reg_sel == 2'd1) & ~halt_reg;
    assign push_req  = store_ok & is_mmio & (reg_sel == 2'd2);

    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign pop        = ~fifo_empty & bus.tx_ready;
    assign push_ok    = push_req & (~fifo_full | pop);
    assign head       = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
    assign count_nib  = 4'(count);

    assign status_word = {24'h0, count_nib, 1'b0, ovf, mis, fifo_full};

    // Select the MMIO register value seen by a load in the window.
    always_comb begin
        mmio_word = 32'h0;
        case (reg_sel)
            2'd0: mmio_word = cycle_count;
            2'd1: mmio_word = exit_reg;
            2'd2: mmio_word = {24'h0, head};
            2'd3: mmio_word = bus.rwam[4] ? mis_addr : status_word;
            default: ;
        endcase
    end

    assign ram_word = mem[word_idx];
    assign src_word = is_mmio ? mmio_word : ram_word;

    // Extract the addressed lane(s) and extend; faults read as zero.
    always_comb begin
        byte_pick = 8'h00;
        case (lane)
            2'd0: byte_pick = src_word[7:0];
            2'd1: byte_pick = src_word[15:8];
            2'd2: byte_pick = src_word[23:16];
            2'd3: byte_pick = src_word[31:24];
            default: ;
        endcase
        half_pick = bus.rwam[1] ? src_word[31:16] : src_word[15:0];
        load_data = 32'h0;
        if (!misaligned) begin
            if (is_byte) begin
                load_data = {{24{~is_unsigned & byte_pick[7]}}, byte_pick};
            end else if (is_half) begin
                load_data = {{16{~is_unsigned & half_pick[15]}}, half_pick};
            end else begin
                load_data = src_word;
            end
        end
    end

    assign bus.rdm       = load_data;
    assign bus.tx_data   = head;
    assign bus.tx_valid  = ~fifo_empty;
    assign bus.halt      = halt_reg;
    assign bus.exit_code = exit_reg;

    // RAM write port; not reset so a store in a reset cycle still lands.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= placed[8*i +: 8];
                end
            end
        end
    end

    // Free-running cycle counter that freezes once the core has halted.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= 32'h0;
        end else if (!halt_reg) begin
            cycle_count <= cycle_count + 32'h1;
        end
    end

    // Capture the first tohost store as the exit code and halt for good.
    always_ff @(posedge clk) begin
        if (reset) begin
            halt_reg <= 1'b0;
            exit_reg <= 32'h0;
        end else if (tohost_we) begin
            halt_reg <= 1'b1;
            exit_reg <= tohost_data;
        end
    end

    // Remember the first misaligned access address.
    always_ff @(posedge clk) begin
        if (reset) begin
            mis      <= 1'b0;
            mis_addr <= 32'h0;
        end else if (misaligned && !mis) begin
            mis      <= 1'b1;
            mis_addr <= bus.rwam;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (push_req && fifo_full && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            fifo_mem[wr_ptr] <= bus.wdm[7:0];
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// RAM traffic, all compared against a byte-level reference model.
module tb_dmem_responder;
    localparam int DW = 1024;
    localparam int FD = 4;
    localparam logic [2:0] MB = 3'b000, MH = 3'b001, MW = 3'b010, MBU = 3'b100, MHU = 3'b101;
    localparam logic [31:0] CYC = 32'h8000_0000, TOH = 32'h8000_0004,
                            TXD = 32'h8000_0008, STA = 32'h8000_000C, MISA = 32'h8000_001C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, wem = 1'b0, tx_ready = 1'b0;
    logic [2:0]  rwmm = MW;
    logic [31:0] rwam = 32'h0, wdm = 32'h0;
    logic        rst_req = 1'b1, rdy_req = 1'b0;

    dmem_responder_if bus();
    assign bus.wem      = wem;
    assign bus.rwmm     = rwmm;
    assign bus.rwam     = rwam;
    assign bus.wdm      = wdm;
    assign bus.tx_ready = tx_ready;

    dmem_responder #(.DEPTH_WORDS(DW), .FIFO_DEPTH(FD)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [7:0]  mb [0:4*DW-1];
    logic [7:0]  fifo_q [$];
    logic [31:0] m_cycle = 0, m_exit = 0, m_mis_addr = 0;
    logic        m_halt = 0, m_mis = 0, m_ovf = 0;

    function automatic int msize(logic [2:0] m);
        if (m == MB || m == MBU) return 1;
        if (m == MH || m == MHU) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_word(logic [31:0] a);
        int idx;
        logic [31:0] st;
        if (a[31] == 1'b0) begin
            idx = int'((a >> 2) % DW) * 4;
            return {mb[idx+3], mb[idx+2], mb[idx+1], mb[idx]};
        end
        case (a[3:2])
            2'd0: return m_cycle;
            2'd1: return m_exit;
            2'd2: return (fifo_q.size() > 0) ? {24'h0, fifo_q[0]} : 32'h0;
            default: begin
                if (a[4]) return m_mis_addr;
                st = 32'(fifo_q.size()) * 16;
                if (fifo_q.size() == FD) st = st + 1;
                if (m_mis) st = st + 2;
                if (m_ovf) st = st + 4;
                return st;
            end
        endcase
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] a, logic [2:0] m);
        int sz;
        int ln;
        logic [31:0] v;
        logic uns;
        sz  = msize(m);
        ln  = int'(a[1:0]);
        uns = (m == MBU) || (m == MHU);
        if ((ln % sz) != 0) return 32'h0;
        v = model_word(a) >> (8 * ln);
        if (sz == 1) begin
            v = v & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Apply the effect of the clock edge that ends the current cycle.
    function automatic void model_edge();
        int sz;
        int ln;
        int idx;
        logic bad_align;
        logic [31:0] ex;
        sz = msize(rwmm);
        ln = int'(rwam[1:0]);
        bad_align = (ln % sz) != 0;
        if (wem && !bad_align && !rwam[31]) begin
            idx = int'((rwam >> 2) % DW) * 4 + ln;
            for (int i = 0; i < sz; i++) mb[idx + i] = wdm[8*i +: 8];
        end
        if (reset) begin
            fifo_q.delete();
            m_cycle = 0; m_exit = 0; m_mis_addr = 0;
            m_halt = 0; m_mis = 0; m_ovf = 0;
            return;
        end
        if (fifo_q.size() > 0 && tx_ready) void'(fifo_q.pop_front());
        if (wem && !bad_align && rwam[31] && rwam[3:2] == 2'd2) begin
            if (fifo_q.size() < FD) fifo_q.push_back(wdm[7:0]);
            else m_ovf = 1;
        end
        if (!m_halt) m_cycle = m_cycle + 1;
        if (wem && !bad_align && rwam[31] && rwam[3:2] == 2'd1 && !m_halt) begin
            ex = 0;
            for (int i = 0; i < sz; i++) ex[8*(ln+i) +: 8] = wdm[8*i +: 8];
            m_halt = 1;
            m_exit = ex;
        end
        if (bad_align && !m_mis) begin
            m_mis = 1;
            m_mis_addr = rwam;
        end
    endfunction

    task automatic drive(input logic w, input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        reset = rst_req; tx_ready = rdy_req;
        wem = w; rwmm = m; rwam = a; wdm = d;
        #1;
    endtask

    task automatic advance();
        model_edge();
        @(posedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] e;
        rst_req = 1; rdy_req = 0;
        drive(0, MW, 0, 0); advance();
        drive(0, MW, CYC, 0);
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL rst_txvalid_during got=%b exp=0", bus.tx_valid); end
        total++; if (bus.halt !== 1'b0) begin bad++; $display("FAIL rst_halt_during got=%b exp=0", bus.halt); end
        advance();
        rst_req = 0;
        drive(0, MW, CYC, 0);
        total++; if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx got=%b/%h exp=0/00", bus.tx_valid, bus.tx_data); end
        total++; if (bus.halt !== 1'b0 || bus.exit_code !== 32'h0) begin bad++; $display("FAIL rst_halt got=%b/%h exp=0/0", bus.halt, bus.exit_code); end
        total++; if (bus.rdm !== 32'h0) begin bad++; $display("FAIL rst_cycle0 got=%h exp=0", bus.rdm); end
        advance();
        for (int k = 1; k <= 4; k++) begin
            drive(0, MW, CYC, 0);
            total++; if (bus.rdm !== 32'(k)) begin bad++; $display("FAIL cycle_k got=%0d exp=%0d", bus.rdm, k); end
            advance();
        end
        drive(0, MW, STA, 0);
        e = model_load(STA, MW);
        total++; if (bus.rdm !== 32'h0 || e !== 32'h0) begin bad++; $display("FAIL rst_status got=%h exp=0 model=%h", bus.rdm, e); end
        advance();
    endtask

    task automatic test_ram_lanes();
        drive(1, MW, 32'h100, 32'hDEAD_BEEF); advance();
        drive(1, MB, 32'h102, 32'h11); advance();
        drive(0, MW, 32'h100, 0);
        total++; if (bus.rdm !== 32'hDE11_BEEF) begin bad++; $display("FAIL lw_merge got=%h exp=de11beef", bus.rdm); end
        advance();
        drive(0, MB, 32'h103, 0);
        total++; if (bus.rdm !== 32'hFFFF_FFDE) begin bad++; $display("FAIL lb_sign got=%h exp=ffffffde", bus.rdm); end
        advance();
        drive(0, MBU, 32'h103, 0);
        total++; if (bus.rdm !== 32'h0000_00DE) begin bad++; $display("FAIL lbu got=%h exp=000000de", bus.rdm); end
        advance();
        drive(0, MH, 32'h102, 0);
        total++; if (bus.rdm !== 32'hFFFF_DE11) begin bad++; $display("FAIL lh_sign got=%h exp=ffffde11", bus.rdm); end
        advance();
        drive(0, MHU, 32'h100, 0);
        total++; if (bus.rdm !== 32'h0000_BEEF) begin bad++; $display("FAIL lhu got=%h exp=0000beef", bus.rdm); end
        advance();
        drive(1, MW, 32'h104, 32'h1111_2222); advance();
        drive(1, MW, 32'h104, 32'h0123_4567);
        total++; if (bus.rdm !== 32'h1111_2222) begin bad++; $display("FAIL same_cycle_old got=%h exp=11112222", bus.rdm); end
        advance();
        drive(0, MW, 32'h104, 0);
        total++; if (bus.rdm !== 32'h0123_4567) begin bad++; $display("FAIL store_visible got=%h exp=01234567", bus.rdm); end
        advance();
    endtask

    task automatic test_misaligned();
        drive(1, MH, 32'h101, 32'hAAAA);
        total++; if (bus.rdm !== 32'h0) begin bad++; $display("FAIL mis_rdm got=%h exp=0", bus.rdm); end
        advance();
        drive(0, MW, 32'h100, 0);
        total++; if (bus.rdm !== 32'hDE11_BEEF) begin bad++; $display("FAIL mis_ram_kept got=%h exp=de11beef", bus.rdm); end
        advance();
        drive(0, MW, STA, 0);
        total++; if (bus.rdm !== 32'h2) begin bad++; $display("FAIL mis_status got=%h exp=2", bus.rdm); end
        advance();
        drive(0, MW, MISA, 0);
        total++; if (bus.rdm !== 32'h101) begin bad++; $display("FAIL mis_addr got=%h exp=101", bus.rdm); end
        advance();
        drive(0, MW, 32'h203, 0);
        total++; if (bus.rdm !== 32'h0) begin bad++; $display("FAIL mis_load got=%h exp=0", bus.rdm); end
        advance();
        drive(1, MH, TXD + 1, 32'h77); advance();
        drive(1, MW, TOH + 2, 32'h5); advance();
        drive(0, MW, MISA, 0);
        total++; if (bus.rdm !== 32'h101) begin bad++; $display("FAIL mis_first_wins got=%h exp=101", bus.rdm); end
        total++; if (bus.tx_valid !== 1'b0 || bus.halt !== 1'b0) begin bad++; $display("FAIL mis_no_effect got=%b/%b exp=0/0", bus.tx_valid, bus.halt); end
        advance();
    endtask

    task automatic test_random_ram();
        logic [2:0] modes [8] = '{MB, MH, MW, MBU, MHU, 3'b011, 3'b110, 3'b111};
        logic [2:0] m;
        logic [31:0] a, e;
        int errs = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, MW, 32'h100 + 32'(4*i), $urandom); advance();
        end
        for (int n = 0; n < 300; n++) begin
            m = modes[$urandom_range(0, 7)];
            a = 32'h100 + 32'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), m, a, $urandom);
            e = model_load(a, m);
            total++;
            if (bus.rdm !== e) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_load a=%h m=%0d got=%h exp=%h", a, m, bus.rdm, e);
            end
            advance();
        end
        for (int i = 0; i < 8; i++) begin
            a = 32'h100 + 32'(4*i);
            drive(0, MW, a, 0);
            e = model_load(a, MW);
            total++; if (bus.rdm !== e) begin bad++; $display("FAIL rand_final a=%h got=%h exp=%h", a, bus.rdm, e); end
            advance();
        end
    endtask

    task automatic test_fifo_overflow();
        rdy_req = 0;
        for (int b = 8'h41; b <= 8'h44; b++) begin
            drive(1, MB, TXD, 32'(b)); advance();
        end
        drive(0, MW, STA, 0);
        total++; if (bus.rdm !== 32'h43) begin bad++; $display("FAIL fifo_status_full got=%h exp=43", bus.rdm); end
        advance();
        drive(0, MW, TXD, 0);
        total++; if (bus.rdm !== 32'h41) begin bad++; $display("FAIL txdata_read got=%h exp=41", bus.rdm); end
        advance();
        drive(1, MB, TXD, 32'h45); advance();
        drive(0, MW, STA, 0);
        total++; if (bus.rdm !== 32'h47 || bus.rdm !== model_load(STA, MW)) begin bad++; $display("FAIL fifo_ovf_status got=%h exp=47", bus.rdm); end
        advance();
        rdy_req = 1;
        for (int i = 0; i < 4; i++) begin
            drive(0, MW, 0, 0);
            total++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'(8'h41 + i)) begin bad++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, bus.tx_valid, bus.tx_data, 8'(8'h41 + i)); end
            advance();
        end
        drive(0, MW, 0, 0);
        total++; if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin bad++; $display("FAIL drain_empty got=%b/%h exp=0/00", bus.tx_valid, bus.tx_data); end
        advance();
        rdy_req = 0;
    endtask

    task automatic test_alias_and_reset();
        drive(1, MW, 32'h0, 32'h1234_5678); advance();
        drive(0, MW, 32'h1000, 0);
        total++; if (bus.rdm !== 32'h1234_5678) begin bad++; $display("FAIL alias got=%h exp=12345678", bus.rdm); end
        advance();
        for (int b = 8'h61; b <= 8'h63; b++) begin
            drive(1, MB, TXD, 32'(b)); advance();
        end
        rdy_req = 1;
        drive(0, MW, 0, 0);
        total++; if (bus.tx_data !== 8'h61) begin bad++; $display("FAIL drain_pre_rst got=%h exp=61", bus.tx_data); end
        advance();
        rst_req = 1;
        drive(1, MW, 32'h8, 32'h0BAD_F00D); advance();
        rst_req = 0;
        drive(0, MW, 32'h8, 0);
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_drain got=%b exp=0", bus.tx_valid); end
        total++; if (bus.rdm !== 32'h0BAD_F00D) begin bad++; $display("FAIL rst_store_commits got=%h exp=0badf00d", bus.rdm); end
        advance();
        drive(0, MW, 32'h0, 0);
        total++; if (bus.rdm !== 32'h1234_5678) begin bad++; $display("FAIL ram_after_rst got=%h exp=12345678", bus.rdm); end
        advance();
        drive(0, MW, STA, 0);
        total++; if (bus.rdm !== 32'h0) begin bad++; $display("FAIL status_after_rst got=%h exp=0", bus.rdm); end
        advance();
        rdy_req = 0;
    endtask

    task automatic test_full_push_pop();
        rdy_req = 0;
        for (int b = 8'h51; b <= 8'h54; b++) begin
            drive(1, MB, TXD, 32'(b)); advance();
        end
        drive(0, MW, STA, 0);
        total++; if (bus.rdm !== 32'h41) begin bad++; $display("FAIL pp_full got=%h exp=41", bus.rdm); end
        advance();
        rdy_req = 1;
        drive(1, MB, TXD, 32'h55); advance();
        rdy_req = 0;
        drive(0, MW, STA, 0);
        total++; if (bus.rdm !== 32'h41) begin bad++; $display("FAIL pp_no_ovf got=%h exp=41", bus.rdm); end
        advance();
        rdy_req = 1;
        for (int i = 0; i < 4; i++) begin
            drive(0, MW, 0, 0);
            total++; if (bus.tx_data !== 8'(8'h52 + i) || bus.tx_data !== fifo_q[0]) begin bad++; $display("FAIL pp_drain_%0d got=%h exp=%h", i, bus.tx_data, 8'(8'h52 + i)); end
            advance();
        end
        drive(0, MW, 0, 0);
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL pp_empty got=%b exp=0", bus.tx_valid); end
        advance();
        rdy_req = 0;
    endtask

    task automatic test_halt();
        logic [31:0] frozen;
        drive(0, MW, CYC, 0);
        total++; if (bus.rdm !== m_cycle) begin bad++; $display("FAIL cycle_model got=%h exp=%h", bus.rdm, m_cycle); end
        advance();
        drive(1, MW, TOH, 32'h2A);
        total++; if (bus.halt !== 1'b0) begin bad++; $display("FAIL halt_early got=%b exp=0", bus.halt); end
        advance();
        drive(0, MW, CYC, 0);
        frozen = m_cycle;
        total++; if (bus.halt !== 1'b1 || bus.exit_code !== 32'h2A) begin bad++; $display("FAIL halt_set got=%b/%h exp=1/2a", bus.halt, bus.exit_code); end
        total++; if (bus.rdm !== frozen) begin bad++; $display("FAIL cycle_at_halt got=%h exp=%h", bus.rdm, frozen); end
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(0, MW, 0, 0); advance();
        end
        drive(0, MW, CYC, 0);
        total++; if (bus.rdm !== frozen) begin bad++; $display("FAIL cycle_frozen got=%h exp=%h", bus.rdm, frozen); end
        advance();
        drive(1, MW, TOH, 32'h7); advance();
        drive(0, MW, TOH, 0);
        total++; if (bus.rdm !== 32'h2A || bus.exit_code !== 32'h2A) begin bad++; $display("FAIL second_tohost got=%h/%h exp=2a", bus.rdm, bus.exit_code); end
        advance();
    endtask

    initial begin
        test_reset();
        test_ram_lanes();
        test_misaligned();
        test_random_ram();
        test_fifo_overflow();
        test_alias_and_reset();
        test_full_push_pop();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
